// File: rtl/decode_hazard_ctrl_if.sv
// Decode-stage hazard controller bundle: decoded instruction fields, writeback
// strobes from the back end, and the issue/stall/flush controls returned to the pipe.
interface decode_hazard_ctrl_if #(
    parameter int REGI_BITS = 4,
    parameter int VECT_BITS = 2
);
    logic                 dec_valid_i;
    logic                 flagNop_i;
    logic                 flagEnd_i;
    logic                 enableJump_i;
    logic                 isOper1Int_i;
    logic                 isOper2Int_i;
    logic                 isOper1V_i;
    logic                 isOper2V_i;
    logic [REGI_BITS-1:0] ioper1_i;
    logic [REGI_BITS-1:0] ioper2_i;
    logic [VECT_BITS-1:0] voper1_i;
    logic [VECT_BITS-1:0] voper2_i;
    logic                 writeResultInt_i;
    logic                 writeResultV_i;
    logic [REGI_BITS-1:0] intRegDest_i;
    logic [VECT_BITS-1:0] vecRegDest_i;
    logic                 int_we_i;
    logic [REGI_BITS-1:0] int_dest_i;
    logic                 vec_we_i;
    logic [VECT_BITS-1:0] vec_dest_i;

    logic                 issue_o;
    logic                 stall_o;
    logic                 bubble_o;
    logic                 flush_o;
    logic                 halt_o;
    logic                 underflow_o;
    logic [1:0]           state_o;

    modport master (
        output dec_valid_i, flagNop_i, flagEnd_i, enableJump_i,
               isOper1Int_i, isOper2Int_i, isOper1V_i, isOper2V_i,
               ioper1_i, ioper2_i, voper1_i, voper2_i,
               writeResultInt_i, writeResultV_i, intRegDest_i, vecRegDest_i,
               int_we_i, int_dest_i, vec_we_i, vec_dest_i,
        input  issue_o, stall_o, bubble_o, flush_o, halt_o, underflow_o, state_o
    );

    modport slave (
        input  dec_valid_i, flagNop_i, flagEnd_i, enableJump_i,
               isOper1Int_i, isOper2Int_i, isOper1V_i, isOper2V_i,
               ioper1_i, ioper2_i, voper1_i, voper2_i,
               writeResultInt_i, writeResultV_i, intRegDest_i, vecRegDest_i,
               int_we_i, int_dest_i, vec_we_i, vec_dest_i,
        output issue_o, stall_o, bubble_o, flush_o, halt_o, underflow_o, state_o
    );
endinterface

// File: rtl/decode_hazard_ctrl.sv
// Scoreboard hazard controller for decode: per-register pending-write counters,
// RAW/saturation stalls, post-jump flush and end-of-program drain/halt sequencing.
module decode_hazard_ctrl #(
    parameter int REGI_BITS    = 4,
    parameter int VECT_BITS    = 2,
    parameter int CNT_BITS     = 2,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    decode_hazard_ctrl_if.slave  bus
);
    localparam int NUM_I   = 2 ** REGI_BITS;
    localparam int NUM_V   = 2 ** VECT_BITS;
    localparam int FC_BITS = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
    localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);
    localparam logic [FC_BITS-1:0]  FC_LOAD = FC_BITS'(FLUSH_CYCLES - 1);
    localparam logic [FC_BITS-1:0]  FC_ONE  = FC_BITS'(1);

    typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, DRAIN = 2'd2, HALT = 2'd3} state_t;

    state_t               state, state_nxt;
    logic [FC_BITS-1:0]   fcnt, fcnt_nxt;
    logic [CNT_BITS-1:0]  pi [NUM_I];
    logic [CNT_BITS-1:0]  pv [NUM_V];
    logic [NUM_I-1:0]     inc_i, dec_i;
    logic [NUM_V-1:0]     inc_v, dec_v;
    logic                 hazard, issue, all_zero, uf_hit, underflow;

    // Hazards look only at registered counts, so a same-cycle writeback never unblocks.
    always_comb begin
        hazard = 1'b0;
        if (!bus.flagNop_i)
            hazard = (bus.isOper1Int_i && pi[bus.ioper1_i] != '0)
                  || (bus.isOper2Int_i && pi[bus.ioper2_i] != '0)
                  || (bus.isOper1V_i   && pv[bus.voper1_i] != '0)
                  || (bus.isOper2V_i   && pv[bus.voper2_i] != '0)
                  || (bus.writeResultInt_i && pi[bus.intRegDest_i] == CNT_MAX)
                  || (bus.writeResultV_i   && pv[bus.vecRegDest_i] == CNT_MAX);
    end

    assign issue = bus.dec_valid_i && (state == RUN) && !hazard;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        inc_i    = '0;
        dec_i    = '0;
        inc_v    = '0;
        dec_v    = '0;
        uf_hit   = 1'b0;
        all_zero = 1'b1;
        for (int i = 0; i < NUM_I; i++) begin
            inc_i[i] = issue && !bus.flagNop_i && bus.writeResultInt_i
                       && (bus.intRegDest_i == REGI_BITS'(i));
            dec_i[i] = bus.int_we_i && (bus.int_dest_i == REGI_BITS'(i));
            if (dec_i[i] && !inc_i[i] && pi[i] == '0) uf_hit = 1'b1;
            if (pi[i] != '0) all_zero = 1'b0;
        end
        for (int v = 0; v < NUM_V; v++) begin
            inc_v[v] = issue && !bus.flagNop_i && bus.writeResultV_i
                       && (bus.vecRegDest_i == VECT_BITS'(v));
            dec_v[v] = bus.vec_we_i && (bus.vec_dest_i == VECT_BITS'(v));
            if (dec_v[v] && !inc_v[v] && pv[v] == '0) uf_hit = 1'b1;
            if (pv[v] != '0) all_zero = 1'b0;
        end
    end

    // NOTE: the counter arrays are plain flops, not RAM, so they are reset like any other state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_I; i++) pi[i] <= '0;
            for (int v = 0; v < NUM_V; v++) pv[v] <= '0;
            underflow <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_I; i++) begin
                if (inc_i[i] && !dec_i[i])                     pi[i] <= pi[i] + CNT_ONE;
                else if (dec_i[i] && !inc_i[i] && pi[i] != '0) pi[i] <= pi[i] - CNT_ONE;
            end
            for (int v = 0; v < NUM_V; v++) begin
                if (inc_v[v] && !dec_v[v])                     pv[v] <= pv[v] + CNT_ONE;
                else if (dec_v[v] && !inc_v[v] && pv[v] != '0) pv[v] <= pv[v] - CNT_ONE;
            end
            if (uf_hit) underflow <= 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            fcnt  <= '0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
        end
    end

    // End takes priority over jump when both flags arrive together.
    always_comb begin
        state_nxt = state;
        fcnt_nxt  = fcnt;
        case (state)
            RUN: begin
                if (issue && bus.flagEnd_i) begin
                    state_nxt = DRAIN;
                end else if (issue && bus.enableJump_i) begin
                    state_nxt = FLUSH;
                    fcnt_nxt  = FC_LOAD;
                end
            end
            FLUSH: begin
                if (fcnt == '0) state_nxt = RUN;
                else            fcnt_nxt  = fcnt - FC_ONE;
            end
            DRAIN:   if (all_zero) state_nxt = HALT;
            HALT:    state_nxt = HALT;
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        bus.issue_o     = issue;
        bus.stall_o     = ((state == RUN) && bus.dec_valid_i && hazard)
                          || (state == DRAIN) || (state == HALT);
        bus.bubble_o    = !issue || bus.flagNop_i;
        bus.flush_o     = (state == FLUSH);
        bus.halt_o      = (state == HALT);
        bus.underflow_o = underflow;
        bus.state_o     = state;
    end
endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Directed bench for decode_hazard_ctrl: RAW stalls, saturation, NOPs, simultaneous
// inc/dec, jump flush, end drain/halt, underflow and async reset.
module tb_decode_hazard_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    decode_hazard_ctrl_if #(.REGI_BITS(4), .VECT_BITS(2)) bus ();

    decode_hazard_ctrl #(
        .REGI_BITS(4), .VECT_BITS(2), .CNT_BITS(2), .FLUSH_CYCLES(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic e_issue, input logic e_stall,
                           input logic e_bubble);
        check1({tag, ".issue"},  bus.issue_o,  e_issue);
        check1({tag, ".stall"},  bus.stall_o,  e_stall);
        check1({tag, ".bubble"}, bus.bubble_o, e_bubble);
    endtask

    task automatic idle();
        bus.dec_valid_i      = 1'b0;
        bus.flagNop_i        = 1'b0;
        bus.flagEnd_i        = 1'b0;
        bus.enableJump_i     = 1'b0;
        bus.isOper1Int_i     = 1'b0;
        bus.isOper2Int_i     = 1'b0;
        bus.isOper1V_i       = 1'b0;
        bus.isOper2V_i       = 1'b0;
        bus.ioper1_i         = '0;
        bus.ioper2_i         = '0;
        bus.voper1_i         = '0;
        bus.voper2_i         = '0;
        bus.writeResultInt_i = 1'b0;
        bus.writeResultV_i   = 1'b0;
        bus.intRegDest_i     = '0;
        bus.vecRegDest_i     = '0;
        bus.int_we_i         = 1'b0;
        bus.int_dest_i       = '0;
        bus.vec_we_i         = 1'b0;
        bus.vec_dest_i       = '0;
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        idle();
        #1;
        check2("rst.state", bus.state_o, 2'd0);
        check1("rst.halt", bus.halt_o, 1'b0);
        check1("rst.underflow", bus.underflow_o, 1'b0);
        check1("rst.flush", bus.flush_o, 1'b0);
        chk_ctl("rst", 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b1;

        // Back-to-back RAW on r3
        idle();
        bus.dec_valid_i = 1'b1;
        bus.isOper1Int_i = 1'b1; bus.ioper1_i = 4'd1;
        bus.isOper2Int_i = 1'b1; bus.ioper2_i = 4'd2;
        bus.writeResultInt_i = 1'b1; bus.intRegDest_i = 4'd3;
        #1 chk_ctl("raw_add", 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        bus.dec_valid_i = 1'b1;
        bus.isOper1Int_i = 1'b1; bus.ioper1_i = 4'd3;
        bus.writeResultInt_i = 1'b1; bus.intRegDest_i = 4'd4;
        #1 chk_ctl("raw_sub_stall", 1'b0, 1'b1, 1'b1);
        tick();
        bus.int_we_i = 1'b1; bus.int_dest_i = 4'd3;
        #1 chk_ctl("raw_wb_cycle", 1'b0, 1'b1, 1'b1);
        tick();
        bus.int_we_i = 1'b0;
        #1 chk_ctl("raw_sub_issue", 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        bus.dec_valid_i = 1'b1;
        bus.isOper1Int_i = 1'b1; bus.ioper1_i = 4'd3;
        bus.int_we_i = 1'b1; bus.int_dest_i = 4'd4;
        #1 chk_ctl("raw_r3_clear", 1'b1, 1'b0, 1'b0);
        tick();

        // Vector pending-count saturation on v1
        idle();
        bus.dec_valid_i = 1'b1;
        bus.writeResultV_i = 1'b1; bus.vecRegDest_i = 2'd1;
        for (int k = 0; k < 3; k++) begin
            #1 check1($sformatf("vsat_write%0d.issue", k), bus.issue_o, 1'b1);
            tick();
        end
        #1 chk_ctl("vsat_4th_stall", 1'b0, 1'b1, 1'b1);
        tick();
        bus.vec_we_i = 1'b1; bus.vec_dest_i = 2'd1;
        #1 chk_ctl("vsat_wb_cycle", 1'b0, 1'b1, 1'b1);
        tick();
        bus.vec_we_i = 1'b0;
        #1 chk_ctl("vsat_4th_issue", 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        bus.vec_we_i = 1'b1; bus.vec_dest_i = 2'd1;
        repeat (3) tick();
        idle();
        bus.dec_valid_i = 1'b1;
        bus.isOper1V_i = 1'b1; bus.voper1_i = 2'd1;
        #1 chk_ctl("vsat_v1_clear", 1'b1, 1'b0, 1'b0);
        tick();

        // NOP with a pending source neither stalls nor counts its destination
        idle();
        bus.dec_valid_i = 1'b1;
        bus.writeResultInt_i = 1'b1; bus.intRegDest_i = 4'd10;
        #1 check1("nop_setup.issue", bus.issue_o, 1'b1);
        tick();
        bus.flagNop_i = 1'b1;
        bus.isOper1Int_i = 1'b1; bus.ioper1_i = 4'd10;
        #1 chk_ctl("nop_no_hazard", 1'b1, 1'b0, 1'b1);
        tick();
        idle();
        bus.int_we_i = 1'b1; bus.int_dest_i = 4'd10;
        tick();
        idle();
        bus.dec_valid_i = 1'b1;
        bus.isOper1Int_i = 1'b1; bus.ioper1_i = 4'd10;
        #1 chk_ctl("nop_not_counted", 1'b1, 1'b0, 1'b0);
        check1("nop.underflow", bus.underflow_o, 1'b0);
        tick();

        // Simultaneous increment and decrement of r5
        idle();
        bus.dec_valid_i = 1'b1;
        bus.writeResultInt_i = 1'b1; bus.intRegDest_i = 4'd5;
        #1 check1("sim_first.issue", bus.issue_o, 1'b1);
        tick();
        bus.int_we_i = 1'b1; bus.int_dest_i = 4'd5;
        #1 check1("sim_incdec.issue", bus.issue_o, 1'b1);
        tick();
        idle();
        bus.dec_valid_i = 1'b1;
        bus.isOper1Int_i = 1'b1; bus.ioper1_i = 4'd5;
        #1 chk_ctl("sim_r5_pending", 1'b0, 1'b1, 1'b1);
        check1("sim.underflow", bus.underflow_o, 1'b0);
        bus.int_we_i = 1'b1; bus.int_dest_i = 4'd5;
        tick();
        bus.int_we_i = 1'b0;
        #1 chk_ctl("sim_r5_clear", 1'b1, 1'b0, 1'b0);
        tick();

        // Jump: flush for exactly two cycles, then back to RUN
        idle();
        bus.dec_valid_i = 1'b1; bus.enableJump_i = 1'b1;
        #1 chk_ctl("jump_issue", 1'b1, 1'b0, 1'b0);
        check1("jump_issue.flush", bus.flush_o, 1'b0);
        tick();
        bus.enableJump_i = 1'b0;
        #1 check1("flush1.flush", bus.flush_o, 1'b1);
        check2("flush1.state", bus.state_o, 2'd1);
        chk_ctl("flush1", 1'b0, 1'b0, 1'b1);
        tick();
        #1 check1("flush2.flush", bus.flush_o, 1'b1);
        check2("flush2.state", bus.state_o, 2'd1);
        check1("flush2.issue", bus.issue_o, 1'b0);
        tick();
        #1 check1("post_flush.flush", bus.flush_o, 1'b0);
        check2("post_flush.state", bus.state_o, 2'd0);
        check1("post_flush.issue", bus.issue_o, 1'b1);
        tick();

        // End with jump also set: end wins, its write to r9 is counted, drain then halt
        idle();
        bus.dec_valid_i = 1'b1;
        bus.writeResultInt_i = 1'b1; bus.intRegDest_i = 4'd8;
        #1 check1("end_pre.issue", bus.issue_o, 1'b1);
        tick();
        bus.flagEnd_i = 1'b1; bus.enableJump_i = 1'b1; bus.intRegDest_i = 4'd9;
        #1 check1("end_issue.issue", bus.issue_o, 1'b1);
        tick();
        idle();
        bus.dec_valid_i = 1'b1;
        #1 check2("drain.state", bus.state_o, 2'd2);
        chk_ctl("drain", 1'b0, 1'b1, 1'b1);
        check1("drain.flush", bus.flush_o, 1'b0);
        bus.int_we_i = 1'b1; bus.int_dest_i = 4'd8;
        tick();
        bus.int_dest_i = 4'd9;
        #1 check2("drain_r9_pending.state", bus.state_o, 2'd2);
        tick();
        bus.int_we_i = 1'b0;
        #1 check2("drain_empty.state", bus.state_o, 2'd2);
        tick();
        #1 check2("halt.state", bus.state_o, 2'd3);
        check1("halt.halt", bus.halt_o, 1'b1);
        chk_ctl("halt", 1'b0, 1'b1, 1'b1);
        repeat (2) tick();
        #1 check1("halt_sticky.halt", bus.halt_o, 1'b1);
        rst = 1'b0;
        #1 check2("halt_rst.state", bus.state_o, 2'd0);
        check1("halt_rst.halt", bus.halt_o, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        idle();
        bus.dec_valid_i = 1'b1;
        bus.isOper1Int_i = 1'b1; bus.ioper1_i = 4'd8;
        bus.isOper2Int_i = 1'b1; bus.ioper2_i = 4'd9;
        #1 chk_ctl("after_halt", 1'b1, 1'b0, 1'b0);
        tick();

        // Underflow on r7, sticky; async reset clears it and discards pending r12
        idle();
        bus.int_we_i = 1'b1; bus.int_dest_i = 4'd7;
        #1 check1("uf_before.underflow", bus.underflow_o, 1'b0);
        tick();
        bus.int_we_i = 1'b0;
        #1 check1("uf_set.underflow", bus.underflow_o, 1'b1);
        bus.dec_valid_i = 1'b1;
        bus.writeResultInt_i = 1'b1; bus.intRegDest_i = 4'd12;
        #1 check1("uf_pend.issue", bus.issue_o, 1'b1);
        tick();
        idle();
        #1 check1("uf_sticky.underflow", bus.underflow_o, 1'b1);
        #2 rst = 1'b0;
        #1 check1("async_rst.underflow", bus.underflow_o, 1'b0);
        check2("async_rst.state", bus.state_o, 2'd0);
        @(negedge clk);
        rst = 1'b1;
        bus.dec_valid_i = 1'b1;
        bus.isOper1Int_i = 1'b1; bus.ioper1_i = 4'd12;
        #1 chk_ctl("rst_discard", 1'b1, 1'b0, 1'b0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/decode_hazard_ctrl.md
Name: decode_hazard_ctrl

Overview:
Scoreboard-based hazard and sequencing controller for the decode stage (decoder, integer/vector register files, ID/EX pipe). It tracks in-flight writes to integer and vector registers and stalls decode on RAW (read-after-write) hazards or pending-count saturation. It turns bubbles into NOPs at ID/EX, flushes the front end after jumps, and drains then halts the core on an end instruction.

Parameters:
REGI_BITS, 4, integer register address width (2**REGI_BITS registers)
VECT_BITS, 2, vector register address width (2**VECT_BITS registers)
CNT_BITS, 2, width of each per-register pending-write counter
FLUSH_CYCLES, 2, cycles flush_o stays high after an issued jump (>=1)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-low reset
dec_valid_i  in  1  decoder holds a valid instruction
flagNop_i, flagEnd_i, enableJump_i  in  1 each  decoded class flags
isOper1Int_i, isOper2Int_i, isOper1V_i, isOper2V_i  in  1 each  operand-type flags
ioper1_i, ioper2_i  in  REGI_BITS each  integer source addresses
voper1_i, voper2_i  in  VECT_BITS each  vector source addresses
writeResultInt_i, writeResultV_i  in  1 each  instruction writes an int / vector register
intRegDest_i  in  REGI_BITS  integer destination
vecRegDest_i  in  VECT_BITS  vector destination
int_we_i  in  1  integer writeback strobe
int_dest_i  in  REGI_BITS  integer writeback address
vec_we_i  in  1  vector writeback strobe
vec_dest_i  in  VECT_BITS  vector writeback address
issue_o  out  1  instruction accepted into ID/EX this cycle
stall_o  out  1  hold PC and IF/ID
bubble_o  out  1  force NOP into ID/EX
flush_o  out  1  clear IF/ID (post-jump)
halt_o  out  1  core halted (sticky)
underflow_o  out  1  sticky error: writeback to a register with zero pending
state_o  out  2  RUN=0, FLUSH=1, DRAIN=2, HALT=3

Behaviour:
- Reset (rst=0, async): state RUN, all counters 0, flush counter 0, halt_o=0, underflow_o=0. Reset mid-operation discards all pending state. Combinational outputs follow the RUN-state equations.
- Hazard detection uses registered counter values only. A writeback does not clear a hazard in the same cycle it arrives; the instruction issues on the next cycle at the earliest.
- hazard = (isOper1Int & pi[ioper1]!=0) | (isOper2Int & pi[ioper2]!=0) | (isOper1V & pv[voper1]!=0) | (isOper2V & pv[voper2]!=0) | (writeResultInt & pi[intRegDest]==2**CNT_BITS-1) | (writeResultV & pv[vecRegDest]==max).
- NOP instructions (flagNop_i=1) never hazard and never touch the counters, but still issue.
- issue_o = dec_valid_i & state==RUN & ~hazard.
- stall_o = (state==RUN & dec_valid_i & hazard) | state==DRAIN | state==HALT.
- bubble_o = ~issue_o, or issue_o with flagNop_i set.
- flush_o = (state==FLUSH).
- halt_o = (state==HALT).
- Counter update each cycle: +1 on issue with the matching write flag and destination; -1 on matching writeback strobe and address. Increment and decrement of the same register in the same cycle produce no net change.
- A decrement at 0 leaves the counter at 0 and sets underflow_o; it stays set until reset.
- Increment at max cannot occur, because the saturation term forces a stall.
- FSM:
  - RUN: issued jump -> FLUSH, flush counter loaded with FLUSH_CYCLES-1. Issued end -> DRAIN.
  - FLUSH: decoder input ignored (no issue). Counter decrements each cycle; at 0 -> RUN.
  - DRAIN: no issue; writebacks still decrement. When all counters are 0 (registered) -> HALT.
  - HALT: absorbing until reset; writebacks still update counters.
- An end instruction with writeResult set counts its destination before entering DRAIN. Jump and end flags set together: end wins -> DRAIN.
- Latency: issue decision is combinational within the cycle. Counter and state changes are visible the next cycle.

Test Plan:
- Back-to-back RAW: issue ADD r3<-r1,r2 (writeResultInt=1). Next cycle, SUB reading r3 -> stall_o=1, bubble_o=1, issue_o=0. Writeback r3 at cycle k -> SUB issues at k+1; pi[3] returns to 0 after its own writeback.
- Vector saturation: with CNT_BITS=2, issue three writes to v1 with no writeback, then a fourth -> fourth stalls with pv[1]=3. One vec writeback to v1 -> fourth issues the following cycle.
- Simultaneous inc/dec: pi[5]=1; issue write to r5 while int_we_i writes r5 in the same cycle -> pi[5] stays 1, no underflow.
- Jump flush: issue jump with FLUSH_CYCLES=2 -> flush_o high exactly 2 cycles, no issue during them, then RUN with state_o=0.
- End drain: two writes pending, issue end -> state_o=2 with stall_o=1. After both writebacks, state_o=3 and halt_o=1 on the next cycle. Remains halted until rst pulses low, then state_o=0 and all counters 0.
- Underflow and async reset: int_we_i to r7 with pi[7]=0 -> underflow_o=1 sticky. Assert rst low mid-cycle -> underflow_o=0 immediately, without waiting for a clock edge.
